// File: rtl/date2stamp_iter.sv
// Iterative local date/time + timezone to UTC seconds-since-epoch converter.
// Walks elapsed years and months one per cycle; valid/ready on both sides.
module date2stamp_iter #(
  parameter int unsigned YEAR_W     = 14,
  parameter int unsigned STAMP_W    = 64,
  parameter int unsigned EPOCH_YEAR = 1970,
  parameter int unsigned TZ_W       = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [YEAR_W-1:0]  year,
  input  logic [3:0]         month,
  input  logic [4:0]         day,
  input  logic [4:0]         hour,
  input  logic [5:0]         minute,
  input  logic [5:0]         second,
  input  logic [TZ_W-1:0]    tz_offset_min,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STAMP_W-1:0] time_stamp,
  output logic               err
);

  typedef enum logic [2:0] {IDLE, CHECK, YEARS, MONTHS, SECS, DONE} state_t;

  localparam int unsigned ACC_W = 32;
  // Two bits of headroom above STAMP_W: one for sign, one to detect overflow.
  localparam int unsigned CW = (STAMP_W + 2 > 56) ? STAMP_W + 2 : 56;
  localparam logic [YEAR_W-1:0] EPOCH = YEAR_W'(EPOCH_YEAR);
  localparam int TZ_MIN = -720;
  localparam int TZ_MAX = 840;

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    return (y[1:0] == 2'b00) &&
           (((y % YEAR_W'(100)) != '0) || ((y % YEAR_W'(400)) == '0));
  endfunction

  function automatic logic [4:0] dim(input logic [3:0] m, input logic [YEAR_W-1:0] y);
    case (m)
      4'd2:                    dim = is_leap(y) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      default:                 dim = 5'd31;
    endcase
  endfunction

  state_t              state, state_n;
  logic [YEAR_W-1:0]   year_r, year_n, iter, iter_n;
  logic [3:0]          month_r, month_n, m_iter, m_iter_n;
  logic [4:0]          day_r, day_n, hour_r, hour_n;
  logic [5:0]          minute_r, minute_n, second_r, second_n;
  logic [TZ_W-1:0]     tz_r, tz_n;
  logic [ACC_W-1:0]    acc, acc_n;
  logic                bad, bad_n;
  logic                in_ready_n, out_valid_n, err_n;
  logic [STAMP_W-1:0]  time_stamp_n;
  logic                bad_c;
  logic [CW-1:0]       local_c;
  logic signed [CW-1:0] tz_ext_c, utc_c;

  // Field validation on the registered request.
  assign bad_c = (year_r < EPOCH) || (month_r == 4'd0) || (month_r > 4'd12) ||
                 (day_r == 5'd0) || (day_r > dim(month_r, year_r)) ||
                 (hour_r > 5'd23) || (minute_r > 6'd59) || (second_r > 6'd59) ||
                 (int'($signed(tz_r)) < TZ_MIN) || (int'($signed(tz_r)) > TZ_MAX);

  assign local_c = (CW'(acc) + CW'(day_r) - CW'(1)) * CW'(86400) +
                   CW'(hour_r) * CW'(3600) + CW'(minute_r) * CW'(60) + CW'(second_r);
  assign tz_ext_c = CW'($signed(tz_r));
  // tz * 60 as tz*64 - tz*4.
  assign utc_c = $signed(local_c) - ((tz_ext_c <<< 6) - (tz_ext_c <<< 2));

  always_comb begin
    state_n      = state;
    year_n       = year_r;
    month_n      = month_r;
    day_n        = day_r;
    hour_n       = hour_r;
    minute_n     = minute_r;
    second_n     = second_r;
    tz_n         = tz_r;
    acc_n        = acc;
    iter_n       = iter;
    m_iter_n     = m_iter;
    bad_n        = bad;
    err_n        = err;
    time_stamp_n = time_stamp;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          year_n       = year;
          month_n      = month;
          day_n        = day;
          hour_n       = hour;
          minute_n     = minute;
          second_n     = second;
          tz_n         = tz_offset_min;
          acc_n        = '0;
          iter_n       = EPOCH;
          m_iter_n     = 4'd1;
          bad_n        = 1'b0;
          err_n        = 1'b0;
          time_stamp_n = '0;
          state_n      = CHECK;
        end
      end
      // Invalid requests still pass through SECS so they report two edges after acceptance.
      CHECK: begin
        if (bad_c) begin
          bad_n   = 1'b1;
          state_n = SECS;
        end else if (year_r == EPOCH) begin
          state_n = (month_r == 4'd1) ? SECS : MONTHS;
        end else begin
          state_n = YEARS;
        end
      end
      YEARS: begin
        acc_n  = acc + ACC_W'(365) + ACC_W'(is_leap(iter));
        iter_n = iter + YEAR_W'(1);
        if (iter + YEAR_W'(1) == year_r)
          state_n = (month_r == 4'd1) ? SECS : MONTHS;
      end
      MONTHS: begin
        acc_n    = acc + ACC_W'(dim(m_iter, year_r));
        m_iter_n = m_iter + 4'd1;
        if (m_iter + 4'd1 == month_r) state_n = SECS;
      end
      SECS: begin
        if (bad || utc_c[CW-1]) begin
          err_n        = 1'b1;
          time_stamp_n = '0;
        end else if (|utc_c[CW-2:STAMP_W]) begin
          err_n        = 1'b1;
          time_stamp_n = '1;
        end else begin
          err_n        = 1'b0;
          time_stamp_n = utc_c[STAMP_W-1:0];
        end
        state_n = DONE;
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    in_ready_n  = (state_n == IDLE);
    out_valid_n = (state_n == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      year_r     <= '0;
      month_r    <= '0;
      day_r      <= '0;
      hour_r     <= '0;
      minute_r   <= '0;
      second_r   <= '0;
      tz_r       <= '0;
      acc        <= '0;
      iter       <= '0;
      m_iter     <= '0;
      bad        <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
      time_stamp <= '0;
    end else begin
      state      <= state_n;
      year_r     <= year_n;
      month_r    <= month_n;
      day_r      <= day_n;
      hour_r     <= hour_n;
      minute_r   <= minute_n;
      second_r   <= second_n;
      tz_r       <= tz_n;
      acc        <= acc_n;
      iter       <= iter_n;
      m_iter     <= m_iter_n;
      bad        <= bad_n;
      in_ready   <= in_ready_n;
      out_valid  <= out_valid_n;
      err        <= err_n;
      time_stamp <= time_stamp_n;
    end
  end

endmodule

// File: tb/tb_date2stamp_iter.sv
// Directed table-driven bench for date2stamp_iter, plus stall and reset sequences.
module tb_date2stamp_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [13:0] year;
  logic [3:0]  month;
  logic [4:0]  day, hour;
  logic [5:0]  minute, second;
  logic [10:0] tz_offset_min;
  logic [63:0] time_stamp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          y, mo, d, h, mi, s, tz;
    logic [63:0] exp_stamp;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[16];

  date2stamp_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .year(year), .month(month), .day(day), .hour(hour), .minute(minute),
    .second(second), .tz_offset_min(tz_offset_min), .out_valid(out_valid),
    .out_ready(out_ready), .time_stamp(time_stamp), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    year          = 14'(v.y);
    month         = 4'(v.mo);
    day           = 5'(v.d);
    hour          = 5'(v.h);
    minute        = 6'(v.mi);
    second        = 6'(v.s);
    tz_offset_min = 11'(v.tz);
  endtask

  task automatic set_vec(input int i, input int y, input int mo, input int d, input int h,
                         input int mi, input int s, input int tz, input logic [63:0] st,
                         input logic e, input int lat);
    vecs[i].y = y;  vecs[i].mo = mo; vecs[i].d = d;  vecs[i].h = h;
    vecs[i].mi = mi; vecs[i].s = s;  vecs[i].tz = tz;
    vecs[i].exp_stamp = st; vecs[i].exp_err = e; vecs[i].exp_lat = lat;
  endtask

  // Accept, wait for the result with a cycle budget, compare, then consume it.
  task automatic run_vec(input vec_t v, input string tag);
    int  lat;
    int  w;
    w = 0;
    while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
    check({tag, " in_ready_before"}, 64'(in_ready), 64'd1);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 300) begin @(posedge clk); lat++; #1; end
    check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
    check({tag, " stamp"}, time_stamp, v.exp_stamp);
    check({tag, " err"}, 64'(err), 64'(v.exp_err));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid_after_xfer"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready_after_xfer"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    vec_t st;
    int   lat;
    int   spurious;

    set_vec(0, 2024,  9,  2, 10, 52, 38,    0, 64'd1725274358, 1'b0, 64);
    set_vec(1, 1970,  1,  1,  0,  0,  0,    0, 64'd0,          1'b0,  2);
    set_vec(2, 2000,  3,  1,  0,  0,  0,    0, 64'd951868800,  1'b0, 34);
    set_vec(3, 2100,  3,  1,  0,  0,  0,    0, 64'd4107542400, 1'b0, 134);
    set_vec(4, 2023,  2, 29,  0,  0,  0,    0, 64'd0,          1'b1,  2);
    set_vec(5, 2024,  2, 29,  0,  0,  0,    0, 64'd1709164800, 1'b0, 57);
    set_vec(6, 2024, 13,  1,  0,  0,  0,    0, 64'd0,          1'b1,  2);
    set_vec(7, 2024,  1,  1, 24,  0,  0,    0, 64'd0,          1'b1,  2);
    set_vec(8, 1969,  1,  1,  0,  0,  0,    0, 64'd0,          1'b1,  2);
    set_vec(9, 1970,  1,  1,  8,  0,  0,  480, 64'd0,          1'b0,  2);
    set_vec(10, 1970, 1,  1,  0,  0,  0,   60, 64'd0,          1'b1,  2);
    set_vec(11, 1970, 1,  1,  0,  0,  0, -300, 64'd18000,      1'b0,  2);
    set_vec(12, 1970, 1,  1,  0,  0,  0,  841, 64'd0,          1'b1,  2);
    set_vec(13, 2024, 12, 31, 23, 59, 59, -720, 64'd1735732799, 1'b0, 67);
    set_vec(14, 2024,  4, 31,  0,  0,  0,    0, 64'd0,          1'b1,  2);
    set_vec(15, 2024,  1,  1,  0, 60,  0,    0, 64'd0,          1'b1,  2);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(vecs[1]);
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset stamp", time_stamp, 64'd0);
    check("reset err", 64'(err), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready after reset", 64'(in_ready), 64'd1);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Stall in DONE while in_valid is held high with a different request.
    drive(vecs[5]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(vecs[1]);
    lat = 0;
    while (!out_valid && lat < 300) begin @(posedge clk); lat++; #1; end
    check("stall latency", 64'(lat), 64'd57);
    for (int c = 0; c < 10; c++) begin
      check("stall out_valid", 64'(out_valid), 64'd1);
      check("stall stamp", time_stamp, 64'd1709164800);
      check("stall in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall release out_valid", 64'(out_valid), 64'd0);
    check("stall release in_ready", 64'(in_ready), 64'd1);
    spurious = 0;
    repeat (5) begin @(posedge clk); #1; if (out_valid) spurious++; end
    check("stall no extra result", 64'(spurious), 64'd0);

    // Reset in the middle of the year walk abandons the request.
    st = vecs[0];
    drive(st);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    spurious = 0;
    repeat (80) begin @(posedge clk); #1; if (out_valid) spurious++; end
    check("midrst no result", 64'(spurious), 64'd0);
    run_vec(vecs[1], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
